// File: rtl/ramb4_s8_s16_fifo_ctrl.sv
// ramb4_s8_s16_fifo_ctrl: byte-in / word-out FIFO controller for a 512x8 / 256x16 dual-port block RAM.
// Bytes pack little-endian into words; words leave through a 2-entry FWFT buffer with valid/ready.
module ramb4_s8_s16_fifo_ctrl #(
    parameter int AF_THRESH = 448
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        WR_EN,
    input  logic [7:0]  WR_DATA,
    output logic        FULL,
    output logic        ALMOST_FULL,
    output logic        WR_ERR,
    output logic [9:0]  BYTE_COUNT,
    output logic        RD_VALID,
    input  logic        RD_READY,
    output logic [15:0] RD_DATA,
    output logic [8:0]  RAM_ADDRA,
    output logic [7:0]  RAM_DIA,
    output logic        RAM_ENA,
    output logic        RAM_WEA,
    output logic [7:0]  RAM_ADDRB,
    output logic        RAM_ENB,
    input  logic [15:0] RAM_DOB
);
    localparam logic [9:0] AF = 10'(AF_THRESH);

    logic [9:0]  wptr;
    logic [8:0]  iptr;
    logic        inflight;
    logic        wr_err;
    logic [15:0] buf0;
    logic [15:0] buf1;
    logic [1:0]  ocnt;
    logic [9:0]  byte_count;
    logic [1:0]  keep;
    logic        full;
    logic        pop;
    logic        accept;
    logic        issue;

    // keep = words left in the buffer after this cycle's pop; a returning word lands at that slot
    always_comb begin
        byte_count = wptr - {iptr, 1'b0};
        full       = byte_count == 10'd512;
        pop        = (ocnt != 2'd0) && RD_READY;
        keep       = ocnt - {1'b0, pop};
        accept     = WR_EN && RSTN && !full;
        issue      = RSTN && byte_count >= 10'd2 && ({1'b0, keep} + {2'b0, inflight}) < 3'd2;
    end

    assign FULL        = full;
    assign ALMOST_FULL = byte_count >= AF;
    assign WR_ERR      = wr_err;
    assign BYTE_COUNT  = byte_count;
    assign RD_VALID    = ocnt != 2'd0;
    assign RD_DATA     = buf0;
    assign RAM_ADDRA   = RSTN ? wptr[8:0] : 9'd0;
    assign RAM_DIA     = WR_DATA;
    assign RAM_ENA     = accept;
    assign RAM_WEA     = accept;
    assign RAM_ADDRB   = RSTN ? iptr[7:0] : 8'd0;
    assign RAM_ENB     = issue;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wptr     <= '0;
            iptr     <= '0;
            inflight <= 1'b0;
            wr_err   <= 1'b0;
            ocnt     <= '0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            wptr     <= wptr + 10'(accept);
            iptr     <= iptr + 9'(issue);
            inflight <= issue;
            wr_err   <= WR_EN && full;
            ocnt     <= keep + {1'b0, inflight};
            buf0     <= (inflight && keep == 2'd0) ? RAM_DOB : (pop ? buf1 : buf0);
            buf1     <= (inflight && keep == 2'd1) ? RAM_DOB : buf1;
        end
    end
endmodule
